// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the two-port MemoryBlock arbiter.
// Optional alignment fault detection is enabled by MEMORY_ARBITER_ALIGN_CHECK_EN.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } access_size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b11)
            || (size == SIZE_HALF && addr_lo[0])
            || (size == SIZE_WORD && addr_lo != 2'b00);
    endfunction

    // Memory returns bytes starting at the address; keep only the accessed width.
    function automatic logic [31:0] zext(input logic [1:0] size, input logic [31:0] value);
        case (size)
            SIZE_BYTE: return {24'h0, value[7:0]};
            SIZE_HALF: return {16'h0, value[15:0]};
            default:   return value;
        endcase
    endfunction

endpackage

// File: rtl/memory_arbiter_rr.sv
// Two-way round-robin picker; grant[0] = port F, grant[1] = port D.
module memory_arbiter_rr
    import memory_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    port_id_t favoured;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (favoured == PORT_F) ? 2'b01 : 2'b10;
        end
    end

    // The port that just won gives up priority to the other one.
    always_ff @(posedge clk) begin
        if (reset) begin
            favoured <= PORT_F;
        end else if (update && grant != 2'b00) begin
            favoured <= grant[0] ? PORT_D : PORT_F;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares a single-port MemoryBlock between fetch (F) and data (D) requesters.
// Define MEMORY_ARBITER_ALIGN_CHECK_EN to add f_fault/d_fault misalignment reporting.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     f_req,
    input  logic [ADDRESS_WIDTH-1:0] f_addr,
    output logic                     f_done,
    output logic [DATA_WIDTH-1:0]    f_rdata,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [1:0]               d_size,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic                     d_done,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [1:0]               mem_size,
    output logic                     mem_write_enable,
    output logic [DATA_WIDTH-1:0]    mem_write_value,
    input  logic [DATA_WIDTH-1:0]    mem_read_value
`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
    ,
    output logic                     f_fault,
    output logic                     d_fault
`endif
);

    arb_state_t               state, state_next;
    logic [1:0]               req_eff, grant;
    logic                     take;
    logic                     f_bad, d_bad;

    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [1:0]               lat_size;
    logic                     lat_we;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    port_id_t                 lat_owner;
    logic                     lat_fault;

    // A port whose done is high this cycle is still holding its old request.
    assign req_eff = {d_req & ~d_done, f_req & ~f_done};

`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
    assign f_bad = (f_addr[1:0] != 2'b00);
    assign d_bad = misaligned(d_size, d_addr[1:0]);
`else
    assign f_bad = 1'b0;
    assign d_bad = 1'b0;
`endif

    memory_arbiter_rr u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req_eff),
        .update (take),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (req_eff != 2'b00) begin
                    take       = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr  <= '0;
            lat_size  <= SIZE_WORD;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_owner <= PORT_F;
            lat_fault <= 1'b0;
        end else if (take) begin
            if (grant[0]) begin
                lat_addr  <= f_addr;
                lat_size  <= SIZE_WORD;
                lat_we    <= 1'b0;
                lat_owner <= PORT_F;
                lat_fault <= f_bad;
            end else begin
                lat_addr  <= d_addr;
                lat_size  <= d_size;
                lat_we    <= d_we;
                lat_wdata <= d_wdata;
                lat_owner <= PORT_D;
                lat_fault <= d_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_done  <= 1'b0;
            d_done  <= 1'b0;
            f_rdata <= '0;
            d_rdata <= '0;
        end else begin
            f_done <= 1'b0;
            d_done <= 1'b0;
            if (state == ACCESS) begin
                if (lat_owner == PORT_F) begin
                    f_done <= 1'b1;
                    if (!lat_fault) f_rdata <= mem_read_value;
                end else begin
                    d_done <= 1'b1;
                    if (!lat_we && !lat_fault) d_rdata <= zext(lat_size, mem_read_value);
                end
            end
        end
    end

`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            f_fault <= 1'b0;
            d_fault <= 1'b0;
        end else begin
            f_fault <= (state == ACCESS) && (lat_owner == PORT_F) && lat_fault;
            d_fault <= (state == ACCESS) && (lat_owner == PORT_D) && lat_fault;
        end
    end
`endif

    assign mem_address      = lat_addr;
    assign mem_size         = lat_size;
    assign mem_write_value  = lat_wdata;
    assign mem_write_enable = (state == ACCESS) && lat_we && !lat_fault;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized self-checking bench for memory_arbiter with a byte-array MemoryBlock model.
// Fault checks are compiled in when MEMORY_ARBITER_ALIGN_CHECK_EN is defined.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_done;
    logic [31:0]   f_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [1:0]    d_size = 2'b10;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_done;
    logic [31:0]   d_rdata;
    logic [AW-1:0] mem_address;
    logic [1:0]    mem_size;
    logic          mem_write_enable;
    logic [31:0]   mem_write_value;
    logic [31:0]   mem_read_value;
`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
    logic          f_fault, d_fault;
`endif

    always #5 clk = ~clk;

    memory_arbiter #(.ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_size(mem_size), .mem_write_enable(mem_write_enable),
        .mem_write_value(mem_write_value), .mem_read_value(mem_read_value)
`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
        , .f_fault(f_fault), .d_fault(d_fault)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;

    // MemoryBlock model: little-endian bytes, reads return 4 bytes from the address.
    logic [7:0]    mem [0:1023];
    logic [7:0]    ref_mem [0:1023];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;
    int            we_cycles = 0, f_done_cnt = 0, d_done_cnt = 0;
    logic [31:0]   exp_d_rdata = '0;
    logic          last_fault = 1'b0;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    always_comb begin
        mem_read_value = '0;
        for (int i = 0; i < 4; i++) mem_read_value[8*i +: 8] = mem[mem_address + AW'(i)];
    end

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 4; i++) mem[pl_addr + AW'(i)] <= pl_data[8*i +: 8];
        end else if (mem_write_enable) begin
            for (int i = 0; i < 4; i++)
                if (i < nbytes(mem_size)) mem[mem_address + AW'(i)] <= mem_write_value[8*i +: 8];
        end
        if (mem_write_enable) we_cycles  <= we_cycles + 1;
        if (f_done)           f_done_cnt <= f_done_cnt + 1;
        if (d_done)           d_done_cnt <= d_done_cnt + 1;
    end

    function automatic logic [31:0] ref_load(input logic [AW-1:0] a, input logic [1:0] sz);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = ref_mem[a + AW'(i)];
        return v;
    endfunction

    task automatic ref_store(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] w);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[a + AW'(i)] = w[8*i +: 8];
    endtask

    task automatic preload_word(input logic [AW-1:0] a, input logic [31:0] w);
        ref_store(a, SIZE_WORD, w);
        pl_addr = a; pl_data = w; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr(input logic [1:0] sz);
        logic [AW-1:0] a = AW'($urandom_range(0, 1023));
        if (sz == SIZE_HALF) a[0] = 1'b0;
        if (sz == SIZE_WORD) a[1:0] = 2'b00;
        return a;
    endfunction

    // One isolated request; lat = negedges from issue cycle to done (-1 on timeout).
    task automatic do_xfer(input bit is_d, input bit we, input logic [1:0] sz, input logic [AW-1:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd);
        @(posedge clk); #1;
        if (is_d) begin d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd; end
        else begin f_req = 1'b1; f_addr = a; end
        lat = -1;
        rd = '0;
        for (int c = 0; c < 10 && lat < 0; c++) begin
            @(negedge clk);
            if (is_d ? d_done : f_done) begin
                lat = c;
                rd = is_d ? d_rdata : f_rdata;
`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
                last_fault = is_d ? d_fault : f_fault;
`endif
            end
        end
        @(posedge clk); #1;
        f_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_d_rdata = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 8;
        if (f_done !== 1'b0)           begin n_fail++; $display("FAIL rst_f_done got %b exp 0", f_done); end
        if (d_done !== 1'b0)           begin n_fail++; $display("FAIL rst_d_done got %b exp 0", d_done); end
        if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", mem_write_enable); end
        if (f_rdata !== 32'h0)         begin n_fail++; $display("FAIL rst_f_rdata got %h exp 0", f_rdata); end
        if (d_rdata !== 32'h0)         begin n_fail++; $display("FAIL rst_d_rdata got %h exp 0", d_rdata); end
        if (mem_address !== '0)        begin n_fail++; $display("FAIL rst_addr got %h exp 0", mem_address); end
        if (mem_size !== 2'b10)        begin n_fail++; $display("FAIL rst_size got %b exp 10", mem_size); end
        if (mem_write_value !== 32'h0) begin n_fail++; $display("FAIL rst_wval got %h exp 0", mem_write_value); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (f_done || d_done || mem_write_enable) begin
            n_fail++; $display("FAIL idle_quiet got f%b d%b we%b exp 000", f_done, d_done, mem_write_enable);
        end
    endtask

    task automatic test_single_fetch();
        int lat, d0, w0; logic [31:0] rd;
        preload_word(10'h010, 32'hDEADBEEF);
        d0 = d_done_cnt; w0 = we_cycles;
        do_xfer(0, 0, SIZE_WORD, 10'h010, 0, lat, rd);
        n_checks += 4;
        if (lat !== 2)                       begin n_fail++; $display("FAIL fetch_lat got %0d exp 2", lat); end
        if (rd !== 32'hDEADBEEF)             begin n_fail++; $display("FAIL fetch_data got %h exp deadbeef", rd); end
        if (d_done_cnt !== d0)               begin n_fail++; $display("FAIL fetch_no_d got %0d exp %0d", d_done_cnt, d0); end
        if (we_cycles !== w0)                begin n_fail++; $display("FAIL fetch_no_we got %0d exp %0d", we_cycles, w0); end
    endtask

    task automatic test_store_load();
        int lat, w0; logic [31:0] rd;
        preload_word(10'h020, 32'h11223344);
        w0 = we_cycles;
        do_xfer(1, 1, SIZE_BYTE, 10'h021, 32'h000000AB, lat, rd);
        ref_store(10'h021, SIZE_BYTE, 32'h000000AB);
        n_checks += 3;
        if (lat !== 2)             begin n_fail++; $display("FAIL store_lat got %0d exp 2", lat); end
        if (we_cycles - w0 !== 1)  begin n_fail++; $display("FAIL store_we_cycles got %0d exp 1", we_cycles - w0); end
        if (rd !== exp_d_rdata)    begin n_fail++; $display("FAIL store_keeps_rdata got %h exp %h", rd, exp_d_rdata); end
        do_xfer(1, 0, SIZE_WORD, 10'h020, 0, lat, rd);
        exp_d_rdata = ref_load(10'h020, SIZE_WORD);
        n_checks += 2;
        if (rd !== 32'h1122AB44)   begin n_fail++; $display("FAIL store_readback got %h exp 1122ab44", rd); end
        if (rd !== exp_d_rdata)    begin n_fail++; $display("FAIL store_readback_model got %h exp %h", rd, exp_d_rdata); end
    endtask

    task automatic test_half_zext();
        int lat; logic [31:0] rd;
        preload_word(10'h040, 32'h8001FFFE);
        do_xfer(1, 0, SIZE_HALF, 10'h042, 0, lat, rd);
        n_checks++;
        if (rd !== 32'h00008001) begin n_fail++; $display("FAIL half_zext got %h exp 00008001", rd); end
        do_xfer(1, 0, SIZE_BYTE, 10'h040, 0, lat, rd);
        n_checks++;
        if (rd !== 32'h000000FE) begin n_fail++; $display("FAIL byte_zext got %h exp 000000fe", rd); end
        do_xfer(1, 0, SIZE_BYTE, 10'h043, 0, lat, rd);
        exp_d_rdata = 32'h00000080;
        n_checks++;
        if (rd !== 32'h00000080) begin n_fail++; $display("FAIL byte_hi_zext got %h exp 00000080", rd); end
    endtask

    // Both ports held; completions must alternate starting with want_first, two cycles apart.
    task automatic run_both(input int count, input bit want_first_d);
        logic [AW-1:0] fa, da; logic [1:0] dsz; int k; bit exp_d;
        fa = rand_addr(SIZE_WORD);
        dsz = 2'($urandom_range(0, 2));
        da = rand_addr(dsz);
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = fa;
        d_req = 1'b1; d_we = 1'b0; d_size = dsz; d_addr = da;
        k = 0;
        for (int c = 0; c < 4 * count + 10 && k < count; c++) begin
            @(negedge clk);
            if (f_done || d_done) begin
                exp_d = want_first_d ^ k[0];
                n_checks += 3;
                if (f_done && d_done) begin n_fail++; $display("FAIL both_double_done at cycle %0d", c); end
                if (d_done !== exp_d) begin n_fail++; $display("FAIL both_order k=%0d got d=%b exp d=%b", k, d_done, exp_d); end
                if (c !== 2 * (k + 1)) begin n_fail++; $display("FAIL both_spacing k=%0d got cycle %0d exp %0d", k, c, 2 * (k + 1)); end
                n_checks++;
                if (d_done) begin
                    exp_d_rdata = ref_load(da, dsz);
                    if (d_rdata !== exp_d_rdata) begin n_fail++; $display("FAIL both_d_data got %h exp %h", d_rdata, exp_d_rdata); end
                end else if (f_rdata !== ref_load(fa, SIZE_WORD)) begin
                    n_fail++; $display("FAIL both_f_data got %h exp %h", f_rdata, ref_load(fa, SIZE_WORD));
                end
                k++;
            end
        end
        n_checks++;
        if (k !== count) begin n_fail++; $display("FAIL both_count got %0d exp %0d", k, count); end
        @(posedge clk); #1;
        f_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk);
        if (!want_first_d ^ count[0]) exp_d_rdata = ref_load(da, dsz);
    endtask

    task automatic test_simultaneous();
        int lat; logic [31:0] rd;
        // Leave the pointer favouring D so the reset must restore F priority.
        do_xfer(0, 0, SIZE_WORD, 10'h010, 0, lat, rd);
        pulse_reset();
        run_both(8, 1'b0);
    endtask

    task automatic test_reset_mid();
        int d0; logic [AW-1:0] a;
        a = 10'h100;
        d0 = d_done_cnt;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_size = SIZE_WORD; d_addr = a; d_wdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL rmid_we_active got %b exp 1", mem_write_enable); end
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL rmid_we_cleared got %b exp 0", mem_write_enable); end
        if (d_done !== 1'b0)           begin n_fail++; $display("FAIL rmid_no_done got %b exp 0", d_done); end
        @(posedge clk); #1 reset = 1'b0;
        exp_d_rdata = '0;
        repeat (3) @(posedge clk);
        n_checks++;
        if (d_done_cnt !== d0) begin n_fail++; $display("FAIL rmid_done_count got %0d exp %0d", d_done_cnt, d0); end
        // Whether the abandoned store landed is left open; adopt whatever the memory holds.
        for (int i = 0; i < 4; i++) ref_mem[a + AW'(i)] = mem[a + AW'(i)];
        run_both(2, 1'b0);
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, wd; logic [AW-1:0] a; logic [1:0] sz; bit is_d, we;
        for (int n = 0; n < 40; n++) begin
            is_d = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            we = (n == 0 || !is_d) ? 1'b0 : 1'($urandom_range(0, 1));
            sz = is_d ? 2'($urandom_range(0, 2)) : SIZE_WORD;
            a = rand_addr(sz);
            wd = $urandom;
            do_xfer(is_d, we, sz, a, wd, lat, rd);
            n_checks += 2;
            if (lat !== 2) begin n_fail++; $display("FAIL rand_lat n=%0d got %0d exp 2", n, lat); end
            if (is_d && we) begin
                ref_store(a, sz, wd);
                if (rd !== exp_d_rdata) begin n_fail++; $display("FAIL rand_store_rdata n=%0d got %h exp %h", n, rd, exp_d_rdata); end
            end else if (is_d) begin
                exp_d_rdata = ref_load(a, sz);
                if (rd !== exp_d_rdata) begin n_fail++; $display("FAIL rand_load n=%0d a=%h sz=%0d got %h exp %h", n, a, sz, rd, exp_d_rdata); end
            end else if (rd !== ref_load(a, SIZE_WORD)) begin
                n_fail++; $display("FAIL rand_fetch n=%0d a=%h got %h exp %h", n, a, rd, ref_load(a, SIZE_WORD));
            end
`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
            n_checks++;
            if (last_fault !== 1'b0) begin n_fail++; $display("FAIL rand_fault n=%0d got 1 exp 0", n); end
`endif
        end
    endtask

`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
    task automatic test_fault();
        int lat, w0; logic [31:0] rd;
        w0 = we_cycles;
        do_xfer(1, 1, SIZE_WORD, 10'h006, 32'hCAFEF00D, lat, rd);
        n_checks += 5;
        if (lat !== 2)            begin n_fail++; $display("FAIL fault_lat got %0d exp 2", lat); end
        if (last_fault !== 1'b1)  begin n_fail++; $display("FAIL fault_d_pulse got %b exp 1", last_fault); end
        if (we_cycles !== w0)     begin n_fail++; $display("FAIL fault_no_we got %0d exp %0d", we_cycles, w0); end
        if (rd !== exp_d_rdata)   begin n_fail++; $display("FAIL fault_rdata got %h exp %h", rd, exp_d_rdata); end
        if ({mem[9], mem[8], mem[7], mem[6]} !== ref_load(10'h006, SIZE_WORD)) begin
            n_fail++; $display("FAIL fault_mem got %h exp %h", {mem[9], mem[8], mem[7], mem[6]}, ref_load(10'h006, SIZE_WORD));
        end
        do_xfer(0, 0, SIZE_WORD, 10'h002, 0, lat, rd);
        n_checks++;
        if (last_fault !== 1'b1)  begin n_fail++; $display("FAIL fault_f_pulse got %b exp 1", last_fault); end
    endtask
`endif

    initial begin
        #1;
        for (int w = 0; w < 256; w++) preload_word(AW'(w * 4), $urandom);
        test_reset();
        test_single_fetch();
        test_store_load();
        test_half_zext();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
        test_fault();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1);
    end

endmodule
